// File: rtl/play_note_scheduler_if.sv
// Bus between the play-mode note scheduler, its song memory and the play datapath.
// The scheduler uses the master modport; the memory/datapath side uses slave.
interface play_note_scheduler_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [9:0]        note_out;
  logic              note_valid;
  logic              busy;
  logic              song_done;

  modport master (
    input  start, stop, pause, loop_en, mem_data,
    output mem_rd, mem_addr, note_out, note_valid, busy, song_done
  );

  modport slave (
    output start, stop, pause, loop_en, mem_data,
    input  mem_rd, mem_addr, note_out, note_valid, busy, song_done
  );
endinterface

// File: rtl/play_note_scheduler.sv
// Play-mode sequencer: fetches song entries, times each note in beat ticks and
// drives the {notes, shift} word to the sound/display path.
module play_note_scheduler #(
  parameter int TICK_PERIOD = 100000,
  parameter int CNT_W       = 20,
  parameter int ADDR_W      = 8,
  parameter int GAP_TICKS   = 1
) (
  input  logic                   vga_clk,
  input  logic                   rst_n,
  play_note_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [CNT_W-1:0]  w_tick_cnt_nxt;
  logic [5:0]        r_remain;
  logic [5:0]        w_remain_nxt;
  logic [9:0]        r_note;
  logic [9:0]        w_note_nxt;
  logic [9:0]        r_note_out;
  logic              r_mem_rd;
  logic              r_note_valid;
  logic              r_busy;
  logic              r_song_done;
  logic              w_song_done_nxt;
  logic              w_note_valid_nxt;
  logic              w_tick;
  logic [5:0]        w_dur;

  assign w_dur  = bus.mem_data[15:10];
  assign w_tick = (r_tick_cnt == CNT_W'(TICK_PERIOD - 1));

  // r_remain counts note beats in PLAY and silent beats in GAP
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_remain_nxt    = r_remain;
    w_note_nxt      = r_note;
    w_song_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_FETCH;
          w_mem_addr_nxt = '0;
          w_tick_cnt_nxt = '0;
          w_remain_nxt   = '0;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_dur == 6'd0) begin
          if (bus.loop_en) begin
            w_state_nxt    = S_FETCH;
            w_mem_addr_nxt = '0;
          end else begin
            w_state_nxt     = S_DONE;
            w_song_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt    = S_PLAY;
          w_remain_nxt   = w_dur;
          w_tick_cnt_nxt = '0;
          w_note_nxt     = {bus.mem_data[7:0], bus.mem_data[9:8]};
        end
      end
      S_PLAY: begin
        if (!bus.pause) begin
          w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
          if (w_tick) begin
            w_remain_nxt = r_remain - 1'b1;
            if (r_remain == 6'd1) begin
              w_mem_addr_nxt = r_mem_addr + 1'b1;
              if (GAP_TICKS > 0) begin
                w_state_nxt  = S_GAP;
                w_remain_nxt = 6'(GAP_TICKS);
              end else begin
                w_state_nxt  = S_FETCH;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (!bus.pause) begin
          w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
          if (w_tick) begin
            w_remain_nxt = r_remain - 1'b1;
            if (r_remain == 6'd1) begin
              w_state_nxt = S_FETCH;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (bus.stop) begin
      w_state_nxt     = S_IDLE;
      w_mem_addr_nxt  = '0;
      w_tick_cnt_nxt  = '0;
      w_remain_nxt    = '0;
      w_note_nxt      = '0;
      w_song_done_nxt = 1'b0;
    end
  end

  // The latched note survives a pause; only the registered output is muted
  assign w_note_valid_nxt = (w_state_nxt == S_PLAY) && !bus.pause;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr   <= '0;
      r_tick_cnt   <= '0;
      r_remain     <= '0;
      r_note       <= '0;
      r_note_out   <= '0;
      r_mem_rd     <= 1'b0;
      r_note_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_song_done  <= 1'b0;
    end else begin
      r_mem_addr   <= w_mem_addr_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_remain     <= w_remain_nxt;
      r_note       <= w_note_nxt;
      r_note_out   <= w_note_valid_nxt ? w_note_nxt : 10'd0;
      r_mem_rd     <= (w_state_nxt == S_FETCH);
      r_note_valid <= w_note_valid_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_song_done  <= w_song_done_nxt;
    end
  end

  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.note_out   = r_note_out;
  assign bus.note_valid = r_note_valid;
  assign bus.busy       = r_busy;
  assign bus.song_done  = r_song_done;

endmodule

// File: tb/tb_play_note_scheduler.sv
// Bench for play_note_scheduler: a monitor logs read strobes, note on/off edges and
// song_done pulses as encoded events; each test pushes the events it expects.
module tb_play_note_scheduler;
  localparam int AW = 2;

  logic vga_clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   obs_q[$];
  int   exp_q[$];
  logic prev_v = 1'b0;
  logic [15:0] rom [4];

  play_note_scheduler_if #(.ADDR_W(AW)) bus ();

  play_note_scheduler #(
    .TICK_PERIOD(4),
    .CNT_W      (20),
    .ADDR_W     (AW),
    .GAP_TICKS  (1)
  ) dut (
    .vga_clk(vga_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Synchronous song memory: data is valid the cycle after the read strobe
  always @(posedge vga_clk) begin
    if (bus.mem_rd) bus.mem_data <= rom[bus.mem_addr];
  end

  // Event types: 1 read(addr), 2 note on(word), 3 note off, 4 song_done
  function automatic int enc(input int t, input int c, input int d);
    return (t << 28) | ((c & 32'h3ffff) << 10) | (d & 32'h3ff);
  endfunction

  always @(negedge vga_clk) begin
    if (bus.mem_rd) obs_q.push_back(enc(1, cyc, int'(bus.mem_addr)));
    if (bus.note_valid && !prev_v) obs_q.push_back(enc(2, cyc, int'(bus.note_out)));
    if (!bus.note_valid && prev_v) obs_q.push_back(enc(3, cyc, 0));
    if (bus.song_done) obs_q.push_back(enc(4, cyc, 0));
    prev_v = bus.note_valid;
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop_en = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    rst_n = 1'b1;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic start_pulse(output int s);
    s = cyc;
    bus.start = 1'b1;
    @(posedge vga_clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic load_one_note();
    rom[0] = 16'h0901;
    rom[1] = 16'h0000;
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge vga_clk);
    checks++;
    if ({bus.mem_rd, bus.note_valid, bus.busy, bus.song_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {bus.mem_rd, bus.note_valid, bus.busy, bus.song_done});
    end
    checks++;
    if (bus.mem_addr !== 2'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d exp=0", bus.mem_addr);
    end
    checks++;
    if (bus.note_out !== 10'h000) begin
      failures++;
      $display("FAIL reset_note got=%h exp=000", bus.note_out);
    end
  endtask

  task automatic test_single_note();
    int s, e, o;
    load_one_note();
    obs_q.delete();
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    exp_q.push_back(enc(2, s + 3, 'h005));
    exp_q.push_back(enc(3, s + 11, 0));
    exp_q.push_back(enc(1, s + 15, 1));
    exp_q.push_back(enc(4, s + 17, 0));
    wait_to(s + 5);
    @(negedge vga_clk);
    checks++;
    if (bus.note_out !== 10'h005 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_mid got=%h/%b exp=005/1", bus.note_out, bus.busy);
    end
    wait_to(s + 18);
    @(negedge vga_clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_drop got=%b exp=0", bus.busy);
    end
    wait_to(s + 25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL single_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL single_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL single_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_loop();
    int s, e, o;
    load_one_note();
    obs_q.delete();
    bus.loop_en = 1'b1;
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(enc(2, s + 3 + 16 * k, 'h005));
      exp_q.push_back(enc(3, s + 11 + 16 * k, 0));
      exp_q.push_back(enc(1, s + 15 + 16 * k, 1));
      exp_q.push_back(enc(1, s + 17 + 16 * k, 0));
    end
    wait_to(s + 34);
    bus.stop = 1'b1;
    wait_to(s + 35);
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    @(negedge vga_clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_addr !== 2'd0) begin
      failures++;
      $display("FAIL loop_stop got=%b/%0d exp=0/0", bus.busy, bus.mem_addr);
    end
    wait_to(s + 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL loop_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL loop_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL loop_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_pause();
    int s, e, o;
    load_one_note();
    obs_q.delete();
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    exp_q.push_back(enc(2, s + 3, 'h005));
    exp_q.push_back(enc(3, s + 6, 0));
    exp_q.push_back(enc(2, s + 9, 'h005));
    exp_q.push_back(enc(3, s + 14, 0));
    exp_q.push_back(enc(1, s + 18, 1));
    exp_q.push_back(enc(4, s + 20, 0));
    wait_to(s + 5);
    bus.pause = 1'b1;
    wait_to(s + 8);
    bus.pause = 1'b0;
    @(negedge vga_clk);
    checks++;
    if (bus.note_out !== 10'h000) begin
      failures++;
      $display("FAIL pause_mute got=%h exp=000", bus.note_out);
    end
    wait_to(s + 26);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL pause_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL pause_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL pause_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_stop();
    int s, s2, e, o;
    load_one_note();
    obs_q.delete();
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    exp_q.push_back(enc(2, s + 3, 'h005));
    exp_q.push_back(enc(3, s + 7, 0));
    wait_to(s + 6);
    bus.stop = 1'b1;
    wait_to(s + 7);
    bus.stop = 1'b0;
    @(negedge vga_clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.note_out !== 10'h000 || bus.note_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_play got=%b/%h/%b exp=0/000/0", bus.busy, bus.note_out, bus.note_valid);
    end
    wait_to(s + 14);
    s2 = cyc;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge vga_clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge vga_clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL stop_start_same got=%b/%b exp=0/0", bus.busy, bus.mem_rd);
    end
    wait_to(s2 + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL stop_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL stop_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL stop_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_addr_wrap();
    int s, e, o, base;
    rom[0] = 16'h0411;
    rom[1] = 16'h0522;
    rom[2] = 16'h0633;
    rom[3] = 16'h0744;
    obs_q.delete();
    start_pulse(s);
    for (int k = 0; k < 5; k++) begin
      base = s + 1 + 10 * k;
      exp_q.push_back(enc(1, base, k % 4));
      exp_q.push_back(enc(2, base + 2, int'({rom[k % 4][7:0], rom[k % 4][9:8]})));
      exp_q.push_back(enc(3, base + 6, 0));
    end
    wait_to(s + 48);
    bus.stop = 1'b1;
    wait_to(s + 49);
    bus.stop = 1'b0;
    wait_to(s + 53);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL wrap_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_async_reset();
    int s, e, o;
    load_one_note();
    obs_q.delete();
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    exp_q.push_back(enc(2, s + 3, 'h005));
    exp_q.push_back(enc(3, s + 11, 0));
    wait_to(s + 12);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd, bus.note_valid, bus.busy, bus.song_done} !== 4'b0000 ||
        bus.note_out !== 10'h000 || bus.mem_addr !== 2'd0) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%0d exp=0000/000/0",
               {bus.mem_rd, bus.note_valid, bus.busy, bus.song_done}, bus.note_out, bus.mem_addr);
    end
    #3;
    rst_n = 1'b1;
    @(posedge vga_clk);
    #1;
    start_pulse(s);
    exp_q.push_back(enc(1, s + 1, 0));
    exp_q.push_back(enc(2, s + 3, 'h005));
    exp_q.push_back(enc(3, s + 11, 0));
    exp_q.push_back(enc(1, s + 15, 1));
    exp_q.push_back(enc(4, s + 17, 0));
    wait_to(s + 24);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL rst_event got=none exp=%08h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL rst_event got=%08h exp=%08h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rst_extra got=%0d exp=0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_loop();
    test_pause();
    test_stop();
    test_addr_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
